// File: rtl/sobel_mag_pipe.sv
// sobel_mag_pipe: multi-lane Sobel gradient magnitude with frame control.
// Optional SOBEL_MAG_DIR_EN adds a quantised direction output per lane.
module sobel_mag_pipe #(
    parameter int IN_W        = 9,
    parameter int OUT_W       = 8,
    parameter int LANES       = 2,
    parameter int NORM_SHIFT  = 9,
    parameter int FRAME_BEATS = 261375,
    parameter int THRESH_W    = 2 * IN_W,
    parameter int HIT_W       = $clog2(FRAME_BEATS * LANES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startEn,
    input  logic [THRESH_W-1:0]    thresh,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  sobelX,
    input  logic [LANES*IN_W-1:0]  sobelY,
    output logic                   out_valid,
    output logic [LANES*OUT_W-1:0] normalisedMag,
`ifdef SOBEL_MAG_DIR_EN
    output logic [LANES*2-1:0]     normalisedDir,
`endif
    output logic                   frame_done,
    output logic [HIT_W-1:0]       hit_count
);

    localparam int SQ_W    = 2 * IN_W - 1;
    localparam int SUM_W   = 2 * IN_W;
    localparam int CNT_W   = $clog2(FRAME_BEATS + 1);
    localparam int MAG_MAX = (2 ** OUT_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [1:0]          drain_q;
    logic [CNT_W-1:0]    beats_q;
    logic [THRESH_W-1:0] thr_q;
    logic                frame_done_q;

    logic accept;
    logic start_take;

    assign in_ready   = (state_q == S_RUN);
    assign accept     = in_valid && in_ready;
    assign start_take = (state_q == S_IDLE) && startEn;

    // Frame controller: start, count accepted beats, drain, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            drain_q      <= 2'd0;
            beats_q      <= '0;
            thr_q        <= THRESH_W'(5632);
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (startEn) begin
                        state_q <= S_RUN;
                        thr_q   <= thresh;
                        beats_q <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        beats_q <= beats_q + CNT_W'(1);
                        if (beats_q == CNT_W'(FRAME_BEATS - 1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= 2'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'd2) begin
                        state_q      <= S_IDLE;
                        frame_done_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign frame_done = frame_done_q;

    // Pipeline state
    logic                        s1_valid_q, s1_valid_d;
    logic [LANES-1:0][SQ_W-1:0]  sqx_q, sqx_d;
    logic [LANES-1:0][SQ_W-1:0]  sqy_q, sqy_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [LANES-1:0][SUM_W-1:0] sum_q, sum_d;
    logic [LANES-1:0]            pass_q, pass_d;
    logic                        s3_valid_q, s3_valid_d;
    logic [LANES-1:0][OUT_W-1:0] mag_q, mag_d;
    logic [HIT_W-1:0]            hit_q, hit_d;

    logic signed [IN_W-1:0]      x_s [LANES];
    logic signed [IN_W-1:0]      y_s [LANES];
    logic signed [SUM_W-1:0]     px  [LANES];
    logic signed [SUM_W-1:0]     py  [LANES];
    logic [LANES-1:0][SUM_W-1:0] shr;
    int                          npass;

`ifdef SOBEL_MAG_DIR_EN
    localparam int DW = IN_W + 3;

    logic [LANES-1:0][1:0] dir1_q, dir1_d;
    logic [LANES-1:0][1:0] dir2_q, dir2_d;
    logic [LANES-1:0][1:0] dir3_q, dir3_d;
    logic [IN_W-1:0]       ax [LANES];
    logic [IN_W-1:0]       ay [LANES];
    logic [DW-1:0]         ax2 [LANES];
    logic [DW-1:0]         ax5 [LANES];
    logic [DW-1:0]         ay2 [LANES];
    logic [DW-1:0]         ay5 [LANES];
    logic [LANES-1:0][1:0] dir_raw;

    // Direction code per lane from absolute values and signs
    always_comb begin
        dir_raw = '0;
        for (int k = 0; k < LANES; k++) begin
            ax[k] = sobelX[k*IN_W+IN_W-1]
                  ? (~sobelX[k*IN_W +: IN_W] + IN_W'(1))
                  : sobelX[k*IN_W +: IN_W];
            ay[k] = sobelY[k*IN_W+IN_W-1]
                  ? (~sobelY[k*IN_W +: IN_W] + IN_W'(1))
                  : sobelY[k*IN_W +: IN_W];
            ax2[k] = DW'(ax[k]) * DW'(2);
            ax5[k] = DW'(ax[k]) * DW'(5);
            ay2[k] = DW'(ay[k]) * DW'(2);
            ay5[k] = DW'(ay[k]) * DW'(5);
            if (ay5[k] < ax2[k]) begin
                dir_raw[k] = 2'd0;
            end else if (ay2[k] > ax5[k]) begin
                dir_raw[k] = 2'd2;
            end else if (sobelX[k*IN_W+IN_W-1]
                         == sobelY[k*IN_W+IN_W-1]) begin
                dir_raw[k] = 2'd1;
            end else begin
                dir_raw[k] = 2'd3;
            end
        end
    end

    // Direction follows the magnitude pipeline, gated by threshold
    always_comb begin
        dir1_d = accept ? dir_raw : dir1_q;
        dir2_d = s1_valid_q ? dir1_q : dir2_q;
        dir3_d = dir3_q;
        if (s2_valid_q) begin
            for (int k = 0; k < LANES; k++) begin
                dir3_d[k] = pass_q[k] ? dir2_q[k] : 2'd0;
            end
        end
    end

    // Direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dir1_q <= '0;
            dir2_q <= '0;
            dir3_q <= '0;
        end else begin
            dir1_q <= dir1_d;
            dir2_q <= dir2_d;
            dir3_q <= dir3_d;
        end
    end

    assign normalisedDir = dir3_q;
`endif

    // Stage 1: square each gradient; data holds on bubbles
    always_comb begin
        s1_valid_d = accept;
        sqx_d      = sqx_q;
        sqy_d      = sqy_q;
        for (int k = 0; k < LANES; k++) begin
            x_s[k] = sobelX[k*IN_W +: IN_W];
            y_s[k] = sobelY[k*IN_W +: IN_W];
            px[k]  = SUM_W'(x_s[k]) * SUM_W'(x_s[k]);
            py[k]  = SUM_W'(y_s[k]) * SUM_W'(y_s[k]);
            if (accept) begin
                sqx_d[k] = px[k][SQ_W-1:0];
                sqy_d[k] = py[k][SQ_W-1:0];
            end
        end
    end

    // Stage 2: sum squares and compare against latched threshold
    always_comb begin
        s2_valid_d = s1_valid_q;
        sum_d      = sum_q;
        pass_d     = pass_q;
        if (s1_valid_q) begin
            for (int k = 0; k < LANES; k++) begin
                sum_d[k]  = SUM_W'(sqx_q[k]) + SUM_W'(sqy_q[k]);
                pass_d[k] = (sum_d[k] >= thr_q);
            end
        end
    end

    // Stage 3: normalise, saturate, and count passing lanes
    always_comb begin
        s3_valid_d = s2_valid_q;
        mag_d      = mag_q;
        npass      = 0;
        for (int k = 0; k < LANES; k++) begin
            shr[k] = sum_q[k] >> NORM_SHIFT;
            if (s2_valid_q) begin
                if (!pass_q[k]) begin
                    mag_d[k] = '0;
                end else if (shr[k] > SUM_W'(MAG_MAX)) begin
                    mag_d[k] = '1;
                end else begin
                    mag_d[k] = shr[k][OUT_W-1:0];
                end
                if (pass_q[k]) begin
                    npass = npass + 1;
                end
            end
        end
        if (start_take) begin
            hit_d = '0;
        end else begin
            hit_d = hit_q + HIT_W'(npass);
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            sqx_q      <= '0;
            sqy_q      <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            pass_q     <= '0;
            s3_valid_q <= 1'b0;
            mag_q      <= '0;
            hit_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            sqx_q      <= sqx_d;
            sqy_q      <= sqy_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            pass_q     <= pass_d;
            s3_valid_q <= s3_valid_d;
            mag_q      <= mag_d;
            hit_q      <= hit_d;
        end
    end

    assign out_valid     = s3_valid_q;
    assign normalisedMag = mag_q;
    assign hit_count     = hit_q;

endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Bench for sobel_mag_pipe: directed frames plus randomized traffic
// checked every cycle against a behavioural model.
module tb_sobel_mag_pipe;

    localparam int IN_W  = 9;
    localparam int OUT_W = 8;
    localparam int LANES = 2;
    localparam int NS    = 9;
    localparam int FB    = 4;
    localparam int HIT_W = $clog2(FB * LANES + 1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   startEn;
    logic [2*IN_W-1:0]      thresh;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  sobelX;
    logic [LANES*IN_W-1:0]  sobelY;
    logic                   out_valid;
    logic [LANES*OUT_W-1:0] normalisedMag;
    logic                   frame_done;
    logic [HIT_W-1:0]       hit_count;
`ifdef SOBEL_MAG_DIR_EN
    logic [LANES*2-1:0]     normalisedDir;
    logic [LANES*2-1:0]     last_dir = '0;
    int                     expd [8][LANES];
`endif

    sobel_mag_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES),
        .NORM_SHIFT(NS), .FRAME_BEATS(FB)
    ) dut (
        .clk(clk), .reset(reset), .startEn(startEn),
        .thresh(thresh), .in_valid(in_valid), .in_ready(in_ready),
        .sobelX(sobelX), .sobelY(sobelY), .out_valid(out_valid),
        .normalisedMag(normalisedMag),
`ifdef SOBEL_MAG_DIR_EN
        .normalisedDir(normalisedDir),
`endif
        .frame_done(frame_done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    function automatic int mag_of(input int x, input int y, input int thr);
        int s;
        s = x * x + y * y;
        if (s < thr) return 0;
        s = s / (2 ** NS);
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int dir_of(input int x, input int y, input int thr);
        int ax, ay;
        if (x * x + y * y < thr) return 0;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        if (5 * ay < 2 * ax) return 0;
        if (2 * ay > 5 * ax) return 2;
        if ((x < 0) == (y < 0)) return 1;
        return 3;
    endfunction

    // Behavioural model: 0 idle, 1 accepting, 2 draining
    int   m_state = 0;
    int   m_beats = 0;
    int   m_thr   = 5632;
    int   m_hits  = 0;
    int   m_done  = -1;
    bit   expv [8];
    int   expm [8][LANES];
    logic [LANES*OUT_W-1:0] last_mag = '0;
    logic [7:0]             ov_hist  = '0;

    always @(negedge clk) begin
        int c, sl, x, y;
        c  = cyc;
        sl = c % 8;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_state == 1});
        chk("out_valid", {31'd0, out_valid}, {31'd0, expv[sl]});
        if (expv[sl]) begin
            for (int k = 0; k < LANES; k++) begin
                chk("mag_lane", 32'(normalisedMag[k*OUT_W +: OUT_W]),
                    expm[sl][k]);
`ifdef SOBEL_MAG_DIR_EN
                chk("dir_lane", 32'(normalisedDir[k*2 +: 2]),
                    expd[sl][k]);
`endif
            end
        end
        if (out_valid) begin
            last_mag = normalisedMag;
`ifdef SOBEL_MAG_DIR_EN
            last_dir = normalisedDir;
`endif
        end
        ov_hist = {ov_hist[6:0], out_valid};
        chk("frame_done", {31'd0, frame_done}, {31'd0, c == m_done});
        if (m_state == 0) chk("hit_count", 32'(hit_count), m_hits);
        expv[sl] = 1'b0;
        if (reset) begin
            m_state = 0;
            m_thr   = 5632;
            m_hits  = 0;
            m_beats = 0;
            m_done  = -1;
            for (int i = 0; i < 8; i++) expv[i] = 1'b0;
        end else if (m_state == 0) begin
            if (startEn) begin
                m_state = 1;
                m_thr   = int'(thresh);
                m_hits  = 0;
                m_beats = 0;
            end
        end else if (m_state == 1) begin
            if (in_valid) begin
                expv[(c + 3) % 8] = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    x = int'($signed(sobelX[k*IN_W +: IN_W]));
                    y = int'($signed(sobelY[k*IN_W +: IN_W]));
                    expm[(c + 3) % 8][k] = mag_of(x, y, m_thr);
`ifdef SOBEL_MAG_DIR_EN
                    expd[(c + 3) % 8][k] = dir_of(x, y, m_thr);
`endif
                    if (x * x + y * y >= m_thr) m_hits++;
                end
                m_beats++;
                if (m_beats == FB) begin
                    m_state = 2;
                    m_done  = c + 4;
                end
            end
        end else begin
            if (c + 1 == m_done) m_state = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int x0, input int y0,
                            input int x1, input int y1);
        sobelX = {x1[IN_W-1:0], x0[IN_W-1:0]};
        sobelY = {y1[IN_W-1:0], y0[IN_W-1:0]};
    endtask

    // One full frame of identical beats; startEn noise in RUN and DRAIN,
    // thresh port scrambled after the start is taken.
    task automatic run_frame(input int x0, input int y0, input int x1,
                             input int y1, input int thr, input bit bub);
        int n;
        set_beat(x0, y0, x1, y1);
        in_valid = 1'b0;
        thresh   = thr[2*IN_W-1:0];
        startEn  = 1'b1;
        step();
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        startEn = 1'b0;
        if (!in_ready) fail_now("frame_start");
        thresh = 18'($urandom_range(0, 262143));
        for (int b = 0; b < FB; b++) begin
            if (bub && b == 2) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            startEn  = (b == 2);
            step();
        end
        in_valid = 1'b0;
        startEn  = 1'b1;
        step();
        startEn = 1'b0;
        n = 0;
        while (!frame_done && n < 20) begin
            step();
            n++;
        end
        if (!frame_done) fail_now("frame_done_wait");
    endtask

    initial begin
        int x0, y0, x1, y1;
        reset    = 1'b1;
        startEn  = 1'b0;
        in_valid = 1'b0;
        thresh   = '0;
        sobelX   = '0;
        sobelY   = '0;
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mag", 32'(normalisedMag), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        reset = 1'b0;
        step();

        run_frame(100, 50, -256, -256, 5632, 1'b0);
        chk("t1_lane0", 32'(last_mag[7:0]), 32'd24);
        chk("t1_lane1", 32'(last_mag[15:8]), 32'd255);
        chk("t1_hits", 32'(hit_count), 32'd8);

        run_frame(40, 60, 40, 60, 5632, 1'b0);
        chk("t2_below", 32'(last_mag[7:0]), 32'd0);
        chk("t2_hits0", 32'(hit_count), 32'd0);
        run_frame(40, 60, 40, 60, 5200, 1'b1);
        chk("t2_equal", 32'(last_mag[7:0]), 32'd10);
        chk("t2_hits8", 32'(hit_count), 32'd8);
        chk("t3_ov_pattern", 32'(ov_hist[4:0]), 32'b11011);

        // Reset mid-frame after two accepted beats
        set_beat(100, 50, 100, 50);
        thresh  = 18'd0;
        startEn = 1'b1;
        step();
        startEn  = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("t4_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_ov", {31'd0, out_valid}, 32'd0);
        chk("t4_mag", 32'(normalisedMag), 32'd0);
        chk("t4_done", {31'd0, frame_done}, 32'd0);
        chk("t4_hits", 32'(hit_count), 32'd0);
        repeat (4) step();
        run_frame(100, 50, 40, 60, 5632, 1'b0);
        chk("t4_rerun_hits", 32'(hit_count), 32'd4);

`ifdef SOBEL_MAG_DIR_EN
        run_frame(100, 10, 10, 100, 5632, 1'b0);
        chk("dir_horiz", 32'(last_dir[1:0]), 32'd0);
        chk("dir_vert", 32'(last_dir[3:2]), 32'd2);
        run_frame(60, 60, 60, -60, 5632, 1'b0);
        chk("dir_diag_same", 32'(last_dir[1:0]), 32'd1);
        chk("dir_diag_opp", 32'(last_dir[3:2]), 32'd3);
        run_frame(10, 10, 60, 60, 5632, 1'b0);
        chk("dir_gated", 32'(last_dir[1:0]), 32'd0);
        chk("dir_gated_mag", 32'(last_mag[7:0]), 32'd0);
`endif

        // Randomized traffic with sporadic starts, bubbles and resets
        for (int i = 0; i < 4000; i++) begin
            x0 = int'($urandom_range(0, 511)) - 256;
            y0 = int'($urandom_range(0, 511)) - 256;
            x1 = int'($urandom_range(0, 511)) - 256;
            y1 = int'($urandom_range(0, 511)) - 256;
            set_beat(x0, y0, x1, y1);
            thresh   = 18'($urandom_range(0, 140000));
            startEn  = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 199) == 0);
            step();
        end
        reset    = 1'b0;
        startEn  = 1'b0;
        in_valid = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
